// File: rtl/exec_wb_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exec_wb_pipe : OSECPU execute stage with one-cycle writeback, operand     |
// |                forwarding, external ALU drive and a held CPDR output port. |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module exec_wb_pipe #(
    parameter int         DW        = 32,
    parameter int         RAW       = 6,
    parameter logic [7:0] OP_LIMM16 = 8'h02,
    parameter int         CNTW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic [RAW-1:0]  ireg_r0,
    output logic [RAW-1:0]  ireg_r1,
    input  logic [DW-1:0]   ireg_d0,
    input  logic [DW-1:0]   ireg_d1,
    output logic [RAW-1:0]  ireg_rw,
    output logic [DW-1:0]   ireg_dw,
    output logic            ireg_we,
    output logic [DW-1:0]   alu_d0,
    output logic [DW-1:0]   alu_d1,
    output logic [3:0]      alu_op,
    input  logic [DW-1:0]   alu_dout,
    output logic            dr_valid,
    output logic [DW-1:0]   dr_data,
    input  logic            dr_ready,
    output logic [CNTW-1:0] retired,
    output logic            err
);
    localparam logic [7:0] OP_CP   = 8'hd2;
    localparam logic [7:0] OP_CPDR = 8'hd3;

    logic [7:0]     op;
    logic [RAW-1:0] opnd0, opnd1, opnd2;
    logic [15:0]    imm16;
    logic           accept;
    logic [DW-1:0]  fwd0, fwd1;
    logic           wb_we, cpdr, undef;
    logic [DW-1:0]  wb_data;

    logic            ireg_we_q,  ireg_we_d;
    logic [RAW-1:0]  ireg_rw_q,  ireg_rw_d;
    logic [DW-1:0]   ireg_dw_q,  ireg_dw_d;
    logic            dr_valid_q, dr_valid_d;
    logic [DW-1:0]   dr_data_q,  dr_data_d;
    logic [CNTW-1:0] retired_q,  retired_d;
    logic            err_q,      err_d;

    assign op     = instr[31:24];
    assign opnd0  = instr[18 +: RAW];
    assign opnd1  = instr[12 +: RAW];
    assign opnd2  = instr[6 +: RAW];
    assign imm16  = instr[15:0];

    // Only an unconsumed CPDR result can hold off the fetch side.
    assign in_ready = !(dr_valid_q && !dr_ready);
    assign accept   = in_valid && in_ready;

    // The register file sees the pending write one cycle late; bypass it.
    assign fwd0 = (ireg_we_q && (ireg_rw_q == opnd1)) ? ireg_dw_q : ireg_d0;
    assign fwd1 = (ireg_we_q && (ireg_rw_q == opnd2)) ? ireg_dw_q : ireg_d1;

    always_comb begin
        ireg_r0 = '0;
        ireg_r1 = '0;
        alu_d0  = '0;
        alu_d1  = '0;
        alu_op  = 4'd0;
        wb_we   = 1'b0;
        wb_data = '0;
        cpdr    = 1'b0;
        undef   = 1'b0;
        if (accept) begin
            if (op == OP_LIMM16) begin
                wb_we   = 1'b1;
                wb_data = {{(DW-16){imm16[15]}}, imm16};
            end else begin
                case (op)
                    OP_CP: begin
                        ireg_r0 = opnd1;
                        wb_we   = 1'b1;
                        wb_data = fwd0;
                    end
                    8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19: begin
                        ireg_r0 = opnd1;
                        ireg_r1 = opnd2;
                        alu_d0  = fwd0;
                        alu_d1  = fwd1;
                        alu_op  = op[3:0];
                        wb_we   = 1'b1;
                        wb_data = alu_dout;
                    end
                    OP_CPDR: begin
                        ireg_r0 = opnd1;
                        cpdr    = 1'b1;
                    end
                    default: undef = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        ireg_we_d = wb_we;
        ireg_rw_d = wb_we ? opnd0 : ireg_rw_q;
        ireg_dw_d = wb_we ? wb_data : ireg_dw_q;
        // A fresh CPDR in the consuming cycle keeps the port valid with new data.
        if (cpdr)
            dr_valid_d = 1'b1;
        else if (dr_valid_q && dr_ready)
            dr_valid_d = 1'b0;
        else
            dr_valid_d = dr_valid_q;
        dr_data_d = cpdr ? fwd0 : dr_data_q;
        retired_d = (accept && !(&retired_q)) ? retired_q + {{(CNTW-1){1'b0}}, 1'b1}
                                              : retired_q;
        err_d     = err_q | undef;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ireg_we_q  <= 1'b0;
            ireg_rw_q  <= '0;
            ireg_dw_q  <= '0;
            dr_valid_q <= 1'b0;
            dr_data_q  <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            ireg_we_q  <= ireg_we_d;
            ireg_rw_q  <= ireg_rw_d;
            ireg_dw_q  <= ireg_dw_d;
            dr_valid_q <= dr_valid_d;
            dr_data_q  <= dr_data_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
        end
    end

    assign ireg_we  = ireg_we_q;
    assign ireg_rw  = ireg_rw_q;
    assign ireg_dw  = ireg_dw_q;
    assign dr_valid = dr_valid_q;
    assign dr_data  = dr_data_q;
    assign retired  = retired_q;
    assign err      = err_q;

endmodule
`default_nettype wire
